alu_iter_mdu: RTL and testbench

- Parametrised, registered successor of the single-cycle ALU.
- Adds the RV32M multiply/divide/remainder ops as iterative multi-cycle units, plus SLTU, behind a start/busy/done handshake.
- Sits in the execute stage of the multi-cycle core. The control FSM stalls on busy and captures result/flags on done.

---
 rtl/alu_iter_mdu.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_iter_mdu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_mdu.sv
// alu_iter_mdu: registered execute-stage ALU with iterative RV32M-style multiply/divide.
//
// Basic ops (add/sub/logic/shift/slt/sltu) and the divide special cases finish in
// one edge. mul/mulh/mulhsu/mulhu use a shift-add loop. div/divu/rem/remu use a
// restoring divider. Both loops retire one bit per edge for WIDTH edges.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start            request, sampled only when idle
//   flush            abort the current operation, no done, outputs held
//   a, b, alu_op     operands and op select, latched when the request is accepted
//   busy             an iterative operation is in flight
//   done             one-cycle pulse, result/zero/cout are valid
//   result           registered result, held until the next done
//   zero             result == 0
//   cout             carry-out of a + ~b + 1 on the latched operands
//
// WIDTH must be even and >= 8.
module alu_iter_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout
);

   localparam int SH_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // MUL: {partial product high half, remaining multiplier bits}
   // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // |multiplicand| or |divisor|
   logic [4:0]         op_q, op_d;
   logic               neg_q, neg_d;     // sign of product / quotient
   logic               aneg_q, aneg_d;   // sign of remainder (follows dividend)
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   result_d;
   logic               zero_d, cout_d, done_d;

   // Result-write request from the next-state logic
   logic               wr;
   logic [WIDTH-1:0]   wr_val, wr_a, wr_b;

   function automatic logic [WIDTH-1:0] basic_res(input logic [4:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
      logic [SH_W-1:0] sh;
      sh = y[SH_W-1:0];
      case (op)
         5'd0:    return x + y;
         5'd1:    return x - y;
         5'd2:    return x & y;
         5'd3:    return x | y;
         5'd4:    return x << sh;
         5'd5:    return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         5'd6:    return x ^ y;
         5'd7:    return x >> sh;
         5'd8:    return $signed(x) >>> sh;
         5'd9:    return {{(WIDTH-1){1'b0}}, (x < y)};
         default: return '0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return s ? (~x + 1'b1) : x;
   endfunction

   // ---------------- shift-add multiply step ----------------
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, prod_fin;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      prod_fin = neg_q ? (~mul_next + 1'b1) : mul_next;
   end

   // ---------------- restoring divide step ----------------
   logic [WIDTH:0]     dv_t;
   logic               dv_ge;
   logic [WIDTH-1:0]   dv_sub, quo_fin, rem_fin;
   logic [2*WIDTH-1:0] dv_next;

   always_comb begin
      dv_t    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      dv_ge   = (dv_t >= {1'b0, opnd_q});
      // t - d always fits WIDTH bits when t >= d because the remainder stays below d
      dv_sub  = dv_t[WIDTH-1:0] - opnd_q;
      dv_next = dv_ge ? {dv_sub, acc_q[WIDTH-2:0], 1'b1}
                      : {dv_t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      quo_fin = neg_q  ? (~dv_next[WIDTH-1:0] + 1'b1)       : dv_next[WIDTH-1:0];
      rem_fin = aneg_q ? (~dv_next[2*WIDTH-1:WIDTH] + 1'b1) : dv_next[2*WIDTH-1:WIDTH];
   end

   // ---------------- next-state / datapath control ----------------
   logic is_mul, is_div, sgn_div, a_s, b_s;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      neg_d    = neg_q;
      aneg_d   = aneg_q;
      a_d      = a_q;
      b_d      = b_q;
      wr       = 1'b0;
      wr_val   = '0;
      wr_a     = a_q;
      wr_b     = b_q;
      is_mul   = (alu_op >= 5'd10) && (alu_op <= 5'd13);
      is_div   = (alu_op >= 5'd14) && (alu_op <= 5'd17);
      sgn_div  = (alu_op == 5'd14) || (alu_op == 5'd16);
      a_s      = 1'b0;
      b_s      = 1'b0;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               a_d  = a;
               b_d  = b;
               op_d = alu_op;
               wr_a = a;
               wr_b = b;
               if (is_mul) begin
                  // mul (low half) is sign-agnostic, so it runs unsigned
                  a_s     = ((alu_op == 5'd11) || (alu_op == 5'd12)) && a[WIDTH-1];
                  b_s     = (alu_op == 5'd11) && b[WIDTH-1];
                  acc_d   = {{WIDTH{1'b0}}, mag(b, b_s)};
                  opnd_d  = mag(a, a_s);
                  neg_d   = a_s ^ b_s;
                  cnt_d   = '0;
                  state_d = MUL;
               end else if (is_div) begin
                  if (b == '0) begin
                     wr     = 1'b1;
                     wr_val = (alu_op <= 5'd15) ? '1 : a;
                  end else if (sgn_div && (a == MIN_NEG) && (b == '1)) begin
                     wr     = 1'b1;
                     wr_val = (alu_op == 5'd14) ? a : '0;
                  end else begin
                     a_s     = sgn_div && a[WIDTH-1];
                     b_s     = sgn_div && b[WIDTH-1];
                     acc_d   = {{WIDTH{1'b0}}, mag(a, a_s)};
                     opnd_d  = mag(b, b_s);
                     neg_d   = a_s ^ b_s;
                     aneg_d  = a_s;
                     cnt_d   = '0;
                     state_d = DIV;
                  end
               end else begin
                  wr     = 1'b1;
                  wr_val = basic_res(alu_op, a, b);
               end
            end
            MUL: begin
               acc_d = mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               // last iteration retires straight into the result register
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  wr      = 1'b1;
                  wr_val  = (op_q == 5'd10) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
                  state_d = IDLE;
               end
            end
            DIV: begin
               acc_d = dv_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  wr      = 1'b1;
                  wr_val  = (op_q <= 5'd15) ? quo_fin : rem_fin;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      result_d = result;
      zero_d   = zero;
      cout_d   = cout;
      done_d   = wr;
      if (wr) begin
         result_d = wr_val;
         zero_d   = (wr_val == '0);
         // carry-out of a + ~b + 1 is exactly "a >= b" unsigned
         cout_d   = (wr_a >= wr_b);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         aneg_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         result  <= '0;
         zero    <= 1'b1;
         cout    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         aneg_q  <= aneg_d;
         a_q     <= a_d;
         b_q     <= b_d;
         result  <= result_d;
         zero    <= zero_d;
         cout    <= cout_d;
         done    <= done_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_iter_mdu.sv
// Self-checking bench for alu_iter_mdu (WIDTH=32): directed test-plan steps,
// randomized ops against an arithmetic reference model, flush/reset aborts.
module tb_alu_iter_mdu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic [4:0]    alu_op = '0;
   logic          busy, done, zero, cout;
   logic [W-1:0]  result;

   int n_vec  = 0;
   int n_miss = 0;

   alu_iter_mdu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .a(a), .b(b), .alu_op(alu_op),
      .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the RV32M definitions.
   function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      longint     sx, sy, ux, uy;
      logic [63:0] p;
      logic       ovf;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = longint'({32'd0, x});
      uy  = longint'({32'd0, y});
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (op)
         5'd0:  return x + y;
         5'd1:  return x - y;
         5'd2:  return x & y;
         5'd3:  return x | y;
         5'd4:  return x << y[4:0];
         5'd5:  return (sx < sy) ? 32'd1 : 32'd0;
         5'd6:  return x ^ y;
         5'd7:  return x >> y[4:0];
         5'd8:  return W'(sx >>> y[4:0]);
         5'd9:  return (ux < uy) ? 32'd1 : 32'd0;
         5'd10: begin p = ux * uy; return p[31:0];  end
         5'd11: begin p = sx * sy; return p[63:32]; end
         5'd12: begin p = sx * uy; return p[63:32]; end
         5'd13: begin p = ux * uy; return p[63:32]; end
         5'd14: return (y == 0) ? '1 : ovf ? x  : W'(sx / sy);
         5'd15: return (y == 0) ? '1 : W'(ux / uy);
         5'd16: return (y == 0) ? x  : ovf ? '0 : W'(sx % sy);
         5'd17: return (y == 0) ? x  : W'(ux % uy);
         default: return '0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [W-1:0] y);
      if (op >= 10 && op <= 13) return W + 1;
      if (op >= 14 && op <= 17 && y != 0 && !((op == 14 || op == 16) && y == '1)) return W + 1;
      return 1;
   endfunction

   // One transaction. Called just after a clock edge (or at a negedge).
   // While the unit is busy, start is toggled randomly with junk operands
   // to show that requests are ignored and operands were latched.
   task automatic run_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] exp;
      int lat, cyc, busy_cyc;
      string t;
      exp = model(op, x, y);
      if (op == 14 && x == 32'h8000_0000 && y == '1) lat = 1;
      else lat = model_lat(op, y);
      t = $sformatf("op%0d a=%h b=%h", op, x, y);
      start = 1'b1; alu_op = op; a = x; b = y;
      @(posedge clk); #1;
      cyc = 1; busy_cyc = 0;
      start = 1'b0; a = $urandom; b = $urandom; alu_op = 5'($urandom);
      while (!done && cyc < 3 * W) begin
         if (busy) busy_cyc++;
         start = 1'($urandom);
         a = $urandom; b = $urandom; alu_op = 5'($urandom);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk({t, " done"},    64'(done), 64'd1);
      chk({t, " latency"}, 64'(cyc), 64'(lat));
      chk({t, " busycyc"}, 64'(busy_cyc), 64'(lat - 1));
      chk({t, " busy@done"}, 64'(busy), 64'd0);
      chk({t, " result"},  64'(result), 64'(exp));
      chk({t, " zero"},    64'(zero), 64'(exp == 0));
      chk({t, " cout"},    64'(cout), 64'(x >= y));
   endtask

   initial begin : main
      logic [W-1:0] r_prev;
      logic         z_prev, c_prev;
      logic [4:0]   rop;
      logic [W-1:0] ra, rb;
      int           n_done;

      // ---- reset state ----
      #12;
      chk("rst busy",   64'(busy), 64'd0);
      chk("rst done",   64'(done), 64'd0);
      chk("rst result", 64'(result), 64'd0);
      chk("rst zero",   64'(zero), 64'd1);
      chk("rst cout",   64'(cout), 64'd0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);

      // ---- test plan directed steps ----
      run_op(5'd1, 32'd5, 32'd7);
      chk("tp sub literal", 64'(result), 64'hFFFF_FFFE);
      run_op(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("tp mulh literal", 64'(result), 64'd0);
      run_op(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("tp mul literal", 64'(result), 64'd1);
      run_op(5'd14, -32'sd7, 32'd2);
      chk("tp div literal", 64'(result), 64'hFFFF_FFFD);
      run_op(5'd16, -32'sd7, 32'd2);
      chk("tp rem literal", 64'(result), 64'hFFFF_FFFF);
      run_op(5'd15, 32'h1234, 32'd0);
      run_op(5'd17, 32'h1234, 32'd0);
      run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("tp ovf div literal", 64'(result), 64'h8000_0000);
      run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(5'd15, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(5'd12, 32'hFFFF_FFFF, 32'd1);
      chk("tp mulhsu literal", 64'(result), 64'hFFFF_FFFF);
      run_op(5'd9, 32'd1, 32'hFFFF_FFFF);
      chk("tp sltu literal", 64'(result), 64'd1);
      run_op(5'd8, 32'h8000_0010, 32'd4);
      run_op(5'd20, 32'd3, 32'd4);

      // ---- randomized ops ----
      for (int i = 0; i < 40; i++) begin
         rop = 5'($urandom_range(0, 31));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 9));
            2: begin ra = 32'h8000_0000; rb = '1; end
            3: ra = rb;
            default: ;
         endcase
         run_op(rop, ra, rb);
      end

      // ---- back-to-back basic ops, one done per edge ----
      for (int i = 0; i < 6; i++) begin
         rop = 5'($urandom_range(0, 9));
         ra = $urandom; rb = $urandom;
         start = 1'b1; alu_op = rop; a = ra; b = rb;
         @(posedge clk); #1;
         chk($sformatf("b2b%0d done", i), 64'(done), 64'd1);
         chk($sformatf("b2b%0d result", i), 64'(result), 64'(model(rop, ra, rb)));
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("b2b done drops", 64'(done), 64'd0);

      // ---- flush mid-MUL, with start asserted alongside flush ----
      r_prev = result; z_prev = zero; c_prev = cout;
      start = 1'b1; alu_op = 5'd13; a = $urandom | 32'h1; b = $urandom | 32'h1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 10; i++) begin
         @(posedge clk); #1;
      end
      chk("flush pre busy", 64'(busy), 64'd1);
      flush = 1'b1; start = 1'b1; alu_op = 5'd0; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      chk("flush busy",   64'(busy), 64'd0);
      chk("flush done",   64'(done), 64'd0);
      chk("flush result", 64'(result), 64'(r_prev));
      chk("flush zero",   64'(zero), 64'(z_prev));
      chk("flush cout",   64'(cout), 64'(c_prev));
      n_done = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (done || busy) n_done++;
      end
      chk("flush no late done", 64'(n_done), 64'd0);

      // ---- async reset mid-DIV, between edges ----
      run_op(5'd0, 32'd5, 32'd7);
      start = 1'b1; alu_op = 5'd15; a = 32'hDEAD_BEEF; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end
      chk("pre-rst busy", 64'(busy), 64'd1);
      #3 reset = 1'b1;
      #1;
      chk("async rst busy",   64'(busy), 64'd0);
      chk("async rst done",   64'(done), 64'd0);
      chk("async rst result", 64'(result), 64'd0);
      chk("async rst zero",   64'(zero), 64'd1);
      chk("async rst cout",   64'(cout), 64'd0);
      @(negedge clk); reset = 1'b0;
      n_done = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (done || busy) n_done++;
      end
      chk("post-rst no done", 64'(n_done), 64'd0);

      // ---- corner cases again after reset ----
      run_op(5'd12, 32'hFFFF_FFFF, 32'd1);
      run_op(5'd9, 32'd1, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
